// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port RAM between IF instruction reads and MEM loads/stores.
// MEM has priority; a streak counter forces an IF grant after MAX_STREAK MEM wins.
module mem_port_arbiter #(
  parameter int unsigned LEN        = 32,
  parameter int unsigned MAX_STREAK = 4,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           if_req,
  input  logic [LEN-1:0] if_addr,
  output logic [LEN-1:0] if_rdata,
  output logic           if_done,
  input  logic           mem_req,
  input  logic           mem_we,
  input  logic [LEN-1:0] mem_addr,
  input  logic [LEN-1:0] mem_wdata,
  output logic [LEN-1:0] mem_rdata,
  output logic           mem_done,
  output logic           if_stall,
  output logic           mem_stall,
  output logic           ram_req,
  output logic           ram_we,
  output logic [LEN-1:0] ram_addr,
  output logic [LEN-1:0] ram_wdata,
  input  logic           ram_ack,
  input  logic [LEN-1:0] ram_rdata,
  output logic           err
);

  localparam int unsigned SW = $clog2(MAX_STREAK + 1);
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY_IF,
    S_BUSY_MEM,
    S_DONE
  } state_t;

  state_t         r_state;
  logic [SW-1:0]  r_streak;
  logic [TW-1:0]  r_timer;
  logic [LEN-1:0] r_if_rdata;
  logic [LEN-1:0] r_mem_rdata;
  logic           r_if_done;
  logic           r_mem_done;
  logic           r_ram_req;
  logic           r_ram_we;
  logic [LEN-1:0] r_ram_addr;
  logic [LEN-1:0] r_ram_wdata;
  logic           r_err;

  logic           w_mem_win;
  logic           w_timeout;
  logic [SW-1:0]  w_streak_inc;

  // MEM wins unless IF is waiting and MEM has already used up its streak
  assign w_mem_win    = mem_req & (~if_req | (r_streak < SW'(MAX_STREAK)));
  assign w_timeout    = (r_timer == TW'(TIMEOUT - 1));
  assign w_streak_inc = (r_streak == SW'(MAX_STREAK)) ? r_streak : r_streak + SW'(1);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_streak    <= '0;
      r_timer     <= '0;
      r_if_rdata  <= '0;
      r_mem_rdata <= '0;
      r_if_done   <= 1'b0;
      r_mem_done  <= 1'b0;
      r_ram_req   <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_err       <= 1'b0;
    end else begin
      r_if_done  <= 1'b0;
      r_mem_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_mem_win) begin
            r_state     <= S_BUSY_MEM;
            r_ram_req   <= 1'b1;
            r_ram_we    <= mem_we;
            r_ram_addr  <= mem_addr;
            r_ram_wdata <= mem_wdata;
            r_timer     <= '0;
            r_streak    <= if_req ? w_streak_inc : '0;
          end else if (if_req) begin
            r_state     <= S_BUSY_IF;
            r_ram_req   <= 1'b1;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= if_addr;
            r_ram_wdata <= '0;
            r_timer     <= '0;
            r_streak    <= '0;
          end
        end
        S_BUSY_IF, S_BUSY_MEM: begin
          if (ram_ack) begin
            r_state   <= S_DONE;
            r_ram_req <= 1'b0;
            if (r_state == S_BUSY_IF) begin
              r_if_rdata <= ram_rdata;
              r_if_done  <= 1'b1;
            end else begin
              if (!r_ram_we) r_mem_rdata <= ram_rdata;
              r_mem_done <= 1'b1;
            end
          end else if (w_timeout) begin
            // abort: complete the requester with zero data and latch the error
            r_state   <= S_DONE;
            r_ram_req <= 1'b0;
            r_err     <= 1'b1;
            if (r_state == S_BUSY_IF) begin
              r_if_rdata <= '0;
              r_if_done  <= 1'b1;
            end else begin
              r_mem_rdata <= '0;
              r_mem_done  <= 1'b1;
            end
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign if_rdata  = r_if_rdata;
  assign if_done   = r_if_done;
  assign mem_rdata = r_mem_rdata;
  assign mem_done  = r_mem_done;
  assign ram_req   = r_ram_req;
  assign ram_we    = r_ram_we;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;
  assign err       = r_err;

  assign if_stall  = if_req & ~r_if_done;
  assign mem_stall = mem_req & ~r_mem_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic, checked
// against a transaction-level model of grants, streaks, timeouts and completions.
module tb_mem_port_arbiter;

  localparam int unsigned LEN        = 32;
  localparam int unsigned MAX_STREAK = 4;
  localparam int unsigned TIMEOUT    = 64;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic           if_req = 1'b0;
  logic [LEN-1:0] if_addr = '0;
  logic [LEN-1:0] if_rdata;
  logic           if_done;
  logic           mem_req = 1'b0;
  logic           mem_we = 1'b0;
  logic [LEN-1:0] mem_addr = '0;
  logic [LEN-1:0] mem_wdata = '0;
  logic [LEN-1:0] mem_rdata;
  logic           mem_done;
  logic           if_stall;
  logic           mem_stall;
  logic           ram_req;
  logic           ram_we;
  logic [LEN-1:0] ram_addr;
  logic [LEN-1:0] ram_wdata;
  logic           ram_ack = 1'b0;
  logic [LEN-1:0] ram_rdata = '0;
  logic           err;

  always #5 clock = ~clock;

  mem_port_arbiter #(.LEN(LEN), .MAX_STREAK(MAX_STREAK), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done),
    .if_stall(if_stall), .mem_stall(mem_stall),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_ack(ram_ack), .ram_rdata(ram_rdata), .err(err)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Transaction model: owner 0=none 1=IF 2=MEM; done_who marks the completion cycle
  int          m_owner, m_wait, m_done_who, m_streak;
  bit          m_err, m_we;
  logic [31:0] m_if_rdata, m_mem_rdata, m_addr, m_wdata;

  function automatic void m_reset();
    m_owner = 0; m_wait = 0; m_done_who = 0; m_streak = 0;
    m_err = 0; m_we = 0;
    m_if_rdata = 0; m_mem_rdata = 0; m_addr = 0; m_wdata = 0;
  endfunction

  function automatic void m_step(input bit ifr, input bit memr, input bit mwe,
                                 input logic [31:0] ia, input logic [31:0] ma,
                                 input logic [31:0] wd, input bit ack,
                                 input logic [31:0] rd);
    if (m_done_who != 0) begin
      m_done_who = 0;
    end else if (m_owner != 0) begin
      if (ack) begin
        m_done_who = m_owner;
        if (m_owner == 1) m_if_rdata = rd;
        else if (!m_we) m_mem_rdata = rd;
        m_owner = 0;
      end else if (m_wait == int'(TIMEOUT) - 1) begin
        m_done_who = m_owner;
        if (m_owner == 1) m_if_rdata = 0;
        else m_mem_rdata = 0;
        m_err = 1;
        m_owner = 0;
      end else begin
        m_wait++;
      end
    end else if (memr && (!ifr || m_streak < int'(MAX_STREAK))) begin
      m_owner = 2; m_we = mwe; m_addr = ma; m_wdata = wd; m_wait = 0;
      m_streak = ifr ? ((m_streak < int'(MAX_STREAK)) ? m_streak + 1 : m_streak) : 0;
    end else if (ifr) begin
      m_owner = 1; m_we = 0; m_addr = ia; m_wdata = 0; m_wait = 0; m_streak = 0;
    end
  endfunction

  bit          ram_auto = 0;
  bit          spur_en = 0;
  bit          rd_fixed = 0;
  logic [31:0] rd_val = 0;
  int          ram_lat = 0;
  int          ram_cnt = 0;
  bit          rand_lat = 0;
  logic        prev_req = 0;
  logic [31:0] q_grants[$];

  task automatic compare_all();
    check("ram_req", 32'(ram_req), 32'(m_owner != 0));
    check("err", 32'(err), 32'(m_err));
    check("if_done", 32'(if_done), 32'(m_done_who == 1));
    check("mem_done", 32'(mem_done), 32'(m_done_who == 2));
    check("if_rdata", if_rdata, m_if_rdata);
    check("mem_rdata", mem_rdata, m_mem_rdata);
    check("one_done", 32'(if_done & mem_done), 32'(0));
    if (m_owner != 0) begin
      check("ram_we", 32'(ram_we), 32'(m_we));
      check("ram_addr", ram_addr, m_addr);
      check("ram_wdata", ram_wdata, m_wdata);
    end
  endtask

  // One clock: RAM responds, stalls checked, edge, model advanced, outputs compared
  task automatic tick();
    bit          s_ifr, s_memr, s_we, s_ack;
    logic [31:0] s_ia, s_ma, s_wd, s_rd;
    if (ram_req) begin
      ram_ack   = (ram_auto && ram_cnt >= ram_lat);
      ram_rdata = rd_fixed ? rd_val : $urandom;
      ram_cnt++;
    end else begin
      ram_cnt   = 0;
      if (rand_lat) ram_lat = $urandom_range(0, 3);
      ram_ack   = spur_en ? 1'($urandom_range(0, 1)) : 1'b0;
      ram_rdata = $urandom;
    end
    #1;
    check("if_stall", 32'(if_stall), 32'(if_req && m_done_who != 1));
    check("mem_stall", 32'(mem_stall), 32'(mem_req && m_done_who != 2));
    s_ifr = if_req; s_memr = mem_req; s_we = mem_we; s_ia = if_addr; s_ma = mem_addr;
    s_wd = mem_wdata; s_ack = ram_ack; s_rd = ram_rdata;
    @(posedge clock);
    m_step(s_ifr, s_memr, s_we, s_ia, s_ma, s_wd, s_ack, s_rd);
    #1;
    compare_all();
    if (ram_req && !prev_req) q_grants.push_back(ram_addr);
    prev_req = ram_req;
  endtask

  task automatic run_until_done(input string tag, input int who, input int budget);
    bit seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (m_done_who == who) seen = 1;
    end
    check(tag, 32'(seen), 32'(1));
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (m_owner != 0 || m_done_who != 0); i++) tick();
    tick();
  endtask

  task automatic rand_reqs();
    if (m_done_who == 1 || !if_req) begin
      if_req  = ($urandom_range(0, 2) == 0);
      if_addr = $urandom;
    end
    if (m_done_who == 2 || !mem_req) begin
      mem_req   = ($urandom_range(0, 2) == 0);
      mem_we    = 1'($urandom_range(0, 1));
      mem_addr  = $urandom;
      mem_wdata = $urandom;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp3[6];
    int          hi_cnt;
    m_reset();
    repeat (3) @(posedge clock);
    #1;
    check("rst_ram_req", 32'(ram_req), 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_wdata", ram_wdata, 0);
    check("rst_dones", 32'({if_done, mem_done, err, ram_we}), 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_mem_rdata", mem_rdata, 0);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    tick();

    // Single IF read returning 0xDEADBEEF one cycle after ram_req
    ram_auto = 1; ram_lat = 1; rd_fixed = 1; rd_val = 32'hDEADBEEF;
    if_req = 1; if_addr = 32'h10;
    tick();
    check("t1_ram_addr", ram_addr, 32'h10);
    check("t1_ram_we", 32'(ram_we), 0);
    run_until_done("t1_done", 1, 20);
    check("t1_rdata", if_rdata, 32'hDEADBEEF);
    check("t1_stall", 32'(if_stall), 0);
    if_req = 0;
    tick();
    check("t1_pulse", 32'(if_done), 0);

    // Spurious acks while idle are ignored
    rd_fixed = 0; spur_en = 1;
    repeat (8) tick();
    spur_en = 0;
    check("t6_if_rdata", if_rdata, 32'hDEADBEEF);
    check("t6_mem_rdata", mem_rdata, 0);

    // Simultaneous requests: MEM store first, then IF
    q_grants.delete();
    if_req = 1; if_addr = 32'h30;
    mem_req = 1; mem_we = 1; mem_addr = 32'h20; mem_wdata = 32'h55;
    tick();
    check("t2_we", 32'(ram_we), 1);
    check("t2_wdata", ram_wdata, 32'h55);
    check("t2_addr", ram_addr, 32'h20);
    run_until_done("t2_mem_done", 2, 20);
    mem_req = 0;
    run_until_done("t2_if_done", 1, 20);
    if_req = 0;
    tick();
    check("t2_ngrant", 32'(q_grants.size()), 2);
    if (q_grants.size() == 2) begin
      check("t2_first", q_grants[0], 32'h20);
      check("t2_second", q_grants[1], 32'h30);
    end
    check("t2_mem_rdata", mem_rdata, 0);

    // Starvation guard with both requesters held
    q_grants.delete();
    rand_lat = 1;
    exp3 = '{32'h200, 32'h200, 32'h200, 32'h200, 32'h100, 32'h200};
    if_req = 1; if_addr = 32'h100;
    mem_req = 1; mem_we = 0; mem_addr = 32'h200; mem_wdata = 0;
    for (int i = 0; i < 300 && q_grants.size() < 6; i++) begin
      tick();
      if (m_done_who == 1) if_req = 0;
    end
    mem_req = 0; if_req = 0;
    check("t3_ngrant", 32'(q_grants.size()), 6);
    for (int i = 0; i < 6 && i < q_grants.size(); i++)
      check($sformatf("t3_grant%0d", i), q_grants[i], exp3[i]);
    drain();

    // Randomized traffic with random RAM latency and spurious acks
    spur_en = 1;
    for (int i = 0; i < 1500; i++) begin
      rand_reqs();
      tick();
    end
    spur_en = 0;
    if_req = 0; mem_req = 0;
    drain();

    // Timeout: RAM never acknowledges
    ram_auto = 0;
    mem_req = 1; mem_we = 0; mem_addr = 32'h40;
    hi_cnt = 0;
    for (int i = 0; i < 200 && m_done_who != 2; i++) begin
      tick();
      if (ram_req) hi_cnt++;
    end
    mem_req = 0;
    check("t4_req_cycles", 32'(hi_cnt), 32'(TIMEOUT));
    check("t4_done", 32'(mem_done), 1);
    check("t4_rdata", mem_rdata, 0);
    repeat (4) tick();
    check("t4_err_sticky", 32'(err), 1);

    // Reset in the middle of a MEM transaction
    mem_req = 1; mem_we = 1; mem_addr = 32'h80; mem_wdata = 32'hA5A5;
    repeat (3) tick();
    check("t5_busy", 32'(ram_req), 1);
    reset = 1'b0;
    #1;
    check("t5_req_drop", 32'(ram_req), 0);
    check("t5_no_done", 32'(mem_done), 0);
    m_reset();
    mem_req = 0; ram_ack = 0;
    repeat (2) @(posedge clock);
    #1;
    check("t5_err_clr", 32'(err), 0);
    check("t5_no_done2", 32'(mem_done), 0);
    reset = 1'b1;
    prev_req = 0;
    ram_auto = 1; rand_lat = 0; ram_lat = 0;
    if_req = 1; if_addr = 32'h44;
    run_until_done("t5_if_done", 1, 20);
    if_req = 0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
